// File: rtl/mutex_pkg.sv
// Shared types and helpers for the N-channel mutex arbiter.
// Holds the FSM state enum, parameter defaults, the owner-index width
// helper and the round-robin pick function used by mutex_arbiter.
package mutex_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int MAX_HOLD_DEF    = 255;
    localparam int MAX_CH          = 32;

    // Owner index width; a single channel still needs one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set bit of cand at or after ptr, wrapping modulo n.
    // Returns 0 when cand is empty; callers qualify with |cand.
    function automatic logic [4:0] rr_pick(
        input logic [31:0] cand,
        input logic [4:0]  ptr,
        input int          n
    );
        logic [4:0] sel;
        logic       found;
        logic [5:0] j;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (i < n) begin
                j = {1'b0, ptr} + 6'(i);
                if (j >= 6'(n)) begin
                    j = j - 6'(n);
                end
                if (!found && cand[j[4:0]]) begin
                    sel   = j[4:0];
                    found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/mutex_arbiter_req_sync.sv
// Per-bit request synchroniser chain with asynchronous reset.
// Ports: clk, rst (async, active-high), d (raw req), q (synchronised).
// STAGES = 0 turns the block into a straight wire.
module req_sync
    import mutex_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_chain
            logic [WIDTH-1:0] stg [STAGES];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < STAGES; i++) begin
                        stg[i] <= '0;
                    end
                end else begin
                    stg[0] <= d;
                    for (int i = 1; i < STAGES; i++) begin
                        stg[i] <= stg[i-1];
                    end
                end
            end

            assign q = stg[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/mutex_arbiter.sv
// N-channel clocked mutex: synchronised level requests, four-phase
// req/gnt handshake, round-robin fairness, break-before-make hand-over.
// Ports: clk, rst (async, active-high), req[N_CH], gnt[N_CH] (one-hot
// or zero), busy, owner[IDX_W] (holds last value), timeout (pulse).
// Optional grant-hold limit enabled by defining MUTEX_ARB_TIMEOUT_EN;
// without it timeout is tied low and grants are held indefinitely.
module mutex_arbiter
    import mutex_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int MAX_HOLD    = MAX_HOLD_DEF,
    parameter int IDX_W       = idx_w(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    output logic [N_CH-1:0]  gnt,
    output logic             busy,
    output logic [IDX_W-1:0] owner,
    output logic             timeout
);

    logic [N_CH-1:0]  req_s;
    logic [N_CH-1:0]  cand;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic             win;
    logic             own_req;
    logic             drop;
    logic             force_rel;
    logic             expire;
    state_t           state;

    req_sync #(
        .WIDTH  (N_CH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (req),
        .q   (req_s)
    );

`ifdef MUTEX_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic [N_CH-1:0]   mask;
    logic              timeout_q;

    assign expire = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    // Counter idles at zero outside GRANT, so entry always starts at 0.
    // A timed-out channel stays masked until its req_s is seen low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt  <= '0;
            mask      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= force_rel;
            mask      <= (mask & req_s)
                       | (force_rel ? (N_CH'(1) << owner) : '0);
            if (state == GRANT) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    assign cand    = req_s & ~mask;
    assign timeout = timeout_q;
`else
    logic unused_hold;

    assign unused_hold = ^MAX_HOLD;
    assign expire      = 1'b0;
    assign cand        = req_s;
    assign timeout     = 1'b0;
`endif

    always_comb begin
        win       = |cand;
        sel       = IDX_W'(rr_pick(32'(cand), 5'(ptr), N_CH));
        own_req   = req_s[owner];
        drop      = (state == GRANT) && !own_req;
        force_rel = (state == GRANT) && own_req && expire;
        ptr_nxt   = (int'(owner) == N_CH - 1) ? '0 : owner + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            owner <= '0;
            ptr   <= '0;
        end else begin
            unique case (state)
                IDLE, RELEASE: begin
                    if (win) begin
                        gnt   <= N_CH'(1) << sel;
                        owner <= sel;
                        busy  <= 1'b1;
                        state <= GRANT;
                    end else begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    // Release cycle gives the mandatory all-zero gap.
                    if (drop || force_rel) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= ptr_nxt;
                        state <= RELEASE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
